tt_loopback_bist: RTL and testbench

//  Parametrised built-in self-test top for the Tiny Tapeout pin interface. Drives configurable

---
 rtl/tt_bist_pkg.sv | 34 +++
 rtl/tt_bist_pattern_gen.sv | 68 ++++++
 rtl/tt_loopback_bist.sv | 178 +++++++++++++++++
 tb/tb_tt_loopback_bist.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_bist_pkg.sv
// Shared definitions for the loopback BIST block.
//  mode_e  : pattern generator modes selected by ui_in[2:1]
//  state_e : run-control FSM states
//  Sel*    : readout select codes on ui_in[7:6]
//  sig_step: one step of the 16-bit receive signature (CRC-CCITT style shift plus data fold)
package tt_bist_pkg;

    typedef enum logic [1:0] {
        ModeLfsr = 2'b00,
        ModeWalk = 2'b01,
        ModeCnt  = 2'b10,
        ModeChk  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StDrain = 2'b10,
        StDone  = 2'b11
    } state_e;

    localparam logic [1:0] SelStatus = 2'b00;
    localparam logic [1:0] SelErr    = 2'b01;
    localparam logic [1:0] SelSigLo  = 2'b10;
    localparam logic [1:0] SelSigHi  = 2'b11;

    localparam logic [15:0] SIG_POLY = 16'h1021;
    localparam logic [15:0] SIG_SEED = 16'hFFFF;

    function automatic logic [15:0] sig_step(input logic [15:0] sig, input logic [7:0] rx);
        return {sig[14:0], 1'b0} ^ (sig[15] ? SIG_POLY : 16'h0000) ^ {8'h00, rx};
    endfunction

endpackage

// File: rtl/tt_bist_pattern_gen.sv
// Pattern generator for the loopback BIST.
//  clk, rst_n : clock, synchronous active-low reset
//  mode       : pattern mode (used for both seeding and stepping)
//  load       : load the mode's start value
//  advance    : step to the next pattern (ignored while load is high)
//  pattern    : current pattern, WIDTH bits, registered
module tt_bist_pattern_gen
    import tt_bist_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter logic [7:0]  LFSR_POLY = 8'hB8,
    parameter logic [7:0]  LFSR_SEED = 8'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  mode_e            mode,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] pattern
);

    localparam logic [7:0]       ChkFull  = 8'h55;
    localparam logic [WIDTH-1:0] Poly     = LFSR_POLY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LfsrSeed = LFSR_SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ChkSeed  = ChkFull[WIDTH-1:0];

    logic [WIDTH-1:0] pattern_q;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] pattern_d;

    always_comb begin
        seed      = '0;
        pattern_d = pattern_q;
        unique case (mode)
            ModeLfsr: begin
                seed      = LfsrSeed;
                pattern_d = (pattern_q >> 1) ^ (pattern_q[0] ? Poly : '0);
            end
            ModeWalk: begin
                seed      = WIDTH'(1);
                // Rotate left within WIDTH; degenerates to a constant 1 when WIDTH is 1.
                pattern_d = (pattern_q << 1) | (pattern_q >> (WIDTH - 1));
            end
            ModeCnt: begin
                seed      = '0;
                pattern_d = pattern_q + WIDTH'(1);
            end
            ModeChk: begin
                seed      = ChkSeed;
                // Inverting 55 within WIDTH bits gives AA within WIDTH bits.
                pattern_d = ~pattern_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= '0;
        end else if (load) begin
            pattern_q <= seed;
        end else if (advance) begin
            pattern_q <= pattern_d;
        end
    end

    assign pattern = pattern_q;

endmodule

// File: rtl/tt_loopback_bist.sv
// Loopback built-in self-test for the Tiny Tapeout pin interface.
// Drives patterns on uio_out, checks them on uio_in LATENCY cycles later, counts mismatches and
// compacts received data into a 16-bit signature.
//  clk, rst_n : clock, synchronous active-low reset
//  ena        : design selected; low aborts to idle and releases uio_oe immediately
//  ui_in      : [0] start (rising edge), [2:1] mode, [7:6] readout select
//  uo_out     : readout (status / error count / signature low / signature high)
//  uio_in     : looped-back pattern
//  uio_out    : pattern, bits >= WIDTH are 0
//  uio_oe     : WIDTH low bits set while running or draining
module tt_loopback_bist
    import tt_bist_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned NUM_PATTERNS = 255,
    parameter int unsigned LATENCY      = 1,
    parameter logic [7:0]  LFSR_POLY    = 8'hB8,
    parameter logic [7:0]  LFSR_SEED    = 8'h01,
    parameter int unsigned ERR_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned MaskInt   = (1 << WIDTH) - 1;
    localparam logic [7:0]  Mask      = MaskInt[7:0];
    localparam logic [15:0] LastIdx   = 16'(NUM_PATTERNS - 1);
    localparam logic [1:0]  LastDrain = 2'(LATENCY - 1);

    state_e            state_q;
    mode_e             mode_q;
    logic              start_q;
    logic [15:0]       pat_cnt_q;
    logic [1:0]        drain_cnt_q;
    logic [WIDTH-1:0]  exp_q [LATENCY];
    logic [LATENCY-1:0] vld_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic              err_sticky_q;
    logic [15:0]       sig_q;

    logic              start_edge;
    logic              start_run;
    logic              advance;
    mode_e             gen_mode;
    logic [WIDTH-1:0]  pattern;
    logic [WIDTH-1:0]  rx;
    logic              busy;
    logic              done;
    logic              pass;
    logic              do_cmp;
    logic              mismatch;
    logic [ERR_W+7:0]  err_ext;
    logic              unused_bits;

    assign start_edge = ui_in[0] & ~start_q;
    assign start_run  = ena && start_edge && (state_q == StIdle || state_q == StDone);
    // Pattern 0 is loaded at the start edge; the last pattern is held through drain.
    assign advance    = ena && (state_q == StRun) && (pat_cnt_q != LastIdx);
    assign gen_mode   = start_run ? mode_e'(ui_in[2:1]) : mode_q;

    assign busy = (state_q == StRun) || (state_q == StDrain);
    assign done = (state_q == StDone);
    assign pass = done && (err_cnt_q == '0);

    assign rx       = uio_in[WIDTH-1:0];
    assign do_cmp   = ena && busy && vld_q[LATENCY-1];
    assign mismatch = (rx != exp_q[LATENCY-1]);

    tt_bist_pattern_gen #(
        .WIDTH    (WIDTH),
        .LFSR_POLY(LFSR_POLY),
        .LFSR_SEED(LFSR_SEED)
    ) u_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (gen_mode),
        .load   (start_run),
        .advance(advance),
        .pattern(pattern)
    );

    assign uio_out = 8'(pattern);
    // ena gates the drivers combinationally so the pads release in the same cycle.
    assign uio_oe  = (busy && ena) ? Mask : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mode_q       <= ModeLfsr;
            start_q      <= 1'b0;
            pat_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            vld_q        <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            sig_q        <= SIG_SEED;
            for (int i = 0; i < LATENCY; i++) begin
                exp_q[i] <= '0;
            end
        end else begin
            start_q <= ui_in[0];

            // Expected-value pipe: entry i holds what uio_in must show i+1 cycles later.
            exp_q[0] <= pattern;
            vld_q[0] <= ena && (state_q == StRun);
            for (int i = 1; i < LATENCY; i++) begin
                exp_q[i] <= exp_q[i-1];
                vld_q[i] <= vld_q[i-1];
            end
            if (!ena) begin
                vld_q <= '0;
            end

            if (do_cmp) begin
                sig_q <= sig_step(sig_q, 8'(rx));
                if (mismatch) begin
                    err_sticky_q <= 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + ERR_W'(1);
                    end
                end
            end

            if (!ena) begin
                state_q <= StIdle;
            end else if (start_run) begin
                state_q      <= StRun;
                mode_q       <= mode_e'(ui_in[2:1]);
                pat_cnt_q    <= '0;
                drain_cnt_q  <= '0;
                err_cnt_q    <= '0;
                err_sticky_q <= 1'b0;
                sig_q        <= SIG_SEED;
            end else begin
                case (state_q)
                    StRun: begin
                        if (pat_cnt_q == LastIdx) begin
                            state_q     <= StDrain;
                            drain_cnt_q <= '0;
                        end else begin
                            pat_cnt_q <= pat_cnt_q + 16'd1;
                        end
                    end
                    StDrain: begin
                        if (drain_cnt_q == LastDrain) begin
                            state_q <= StDone;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign err_ext = {8'h00, err_cnt_q};

    always_comb begin
        uo_out = 8'h00;
        unique case (ui_in[7:6])
            SelStatus: uo_out = {4'b0000, err_sticky_q, pass, done, busy};
            SelErr:    uo_out = err_ext[7:0];
            SelSigLo:  uo_out = sig_q[7:0];
            SelSigHi:  uo_out = sig_q[15:8];
        endcase
    end

    // Reserved inputs and bits beyond the active width are deliberately ignored.
    assign unused_bits = ^{ui_in[5:3], uio_in, err_ext};

endmodule

// File: tb/tb_tt_loopback_bist.sv
module tb_tt_loopback_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ena;
    logic [7:0] ui0, ui1, rx0, rx1;
    logic [7:0] uo0, uo1, out0, out1, oe0, oe1;

    int n_tests = 0;
    int n_fail  = 0;

    // dut0: full width, short runs; dut1: narrow width, long runs, two-cycle loopback.
    tt_loopback_bist #(
        .WIDTH(8), .NUM_PATTERNS(16), .LATENCY(1),
        .LFSR_POLY(8'hB8), .LFSR_SEED(8'h01), .ERR_W(8)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui0), .uo_out(uo0),
        .uio_in(rx0), .uio_out(out0), .uio_oe(oe0)
    );

    tt_loopback_bist #(
        .WIDTH(4), .NUM_PATTERNS(300), .LATENCY(2),
        .LFSR_POLY(8'hB8), .LFSR_SEED(8'h01), .ERR_W(8)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui1), .uo_out(uo1),
        .uio_in(rx1), .uio_out(out1), .uio_oe(oe1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int n_of(input int d); return (d == 0) ? 16 : 300; endfunction
    function automatic int l_of(input int d); return (d == 0) ? 1 : 2; endfunction
    function automatic int w_of(input int d); return (d == 0) ? 8 : 4; endfunction
    function automatic logic [7:0] mask_of(input int d);
        return (d == 0) ? 8'hFF : 8'h0F;
    endfunction

    // k-th pattern of a run, computed directly from the mode definitions.
    function automatic logic [7:0] pat(input int d, input int mode, input int k);
        logic [7:0] m = mask_of(d);
        logic [7:0] p;
        int w = w_of(d);
        case (mode)
            0: begin
                p = 8'h01 & m;
                for (int i = 0; i < k; i++) p = (p >> 1) ^ (p[0] ? (8'hB8 & m) : 8'h00);
            end
            1:       p = 8'(1 << (k % w));
            2:       p = 8'(k % (1 << w));
            default: p = (k % 2 == 0) ? (8'h55 & m) : (8'hAA & m);
        endcase
        return p;
    endfunction

    function automatic logic [15:0] sig_fn(input logic [15:0] s, input logic [7:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, r};
    endfunction

    // Loopback channel faults: 0 clean, 1 bit3 stuck low, 2 inverted, 3 all zero,
    // 4 clean with junk on the bits outside the active width.
    function automatic logic [7:0] flt(input int kind, input logic [7:0] v, input logic [7:0] m);
        case (kind)
            1:       return v & 8'hF7;
            2:       return ~v;
            3:       return 8'h00;
            4:       return v | (~m & 8'hB0);
            default: return v;
        endcase
    endfunction

    function automatic logic [7:0] get_uo(input int d);  return (d == 0) ? uo0 : uo1;   endfunction
    function automatic logic [7:0] get_out(input int d); return (d == 0) ? out0 : out1; endfunction
    function automatic logic [7:0] get_oe(input int d);  return (d == 0) ? oe0 : oe1;   endfunction
    function automatic logic [7:0] get_ui(input int d);  return (d == 0) ? ui0 : ui1;   endfunction

    task automatic set_ui(input int d, input logic [7:0] v);
        if (d == 0) ui0 = v; else ui1 = v;
    endtask

    task automatic set_rx(input int d, input logic [7:0] v);
        if (d == 0) rx0 = v; else rx1 = v;
    endtask

    task automatic read_uo(input int d, input logic [1:0] sel, output logic [7:0] v);
        logic [7:0] u = get_ui(d);
        set_ui(d, {sel, u[5:0]});
        #1;
        v = get_uo(d);
    endtask

    // ---------------- per-cycle compare ----------------
    logic       cmp_on = 1'b0;
    int         cmp_d = 0;
    logic [7:0] exp_oe, exp_uo, exp_out;
    logic       exp_out_vld;

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_uio_oe", {8'h00, get_oe(cmp_d)}, {8'h00, exp_oe});
            chk("cyc_status", {8'h00, get_uo(cmp_d)}, {8'h00, exp_uo});
            if (exp_out_vld) chk("cyc_uio_out", {8'h00, get_out(cmp_d)}, {8'h00, exp_out});
        end
    end

    // One run on DUT d. stop_at >= 0 interrupts at that cycle with ena low (or reset if stop_rst).
    task automatic run(input int d, input int mode, input int fault_k, input int stop_at,
                       input bit stop_rst);
        int          n = n_of(d);
        int          l = l_of(d);
        logic [7:0]  m = mask_of(d);
        logic [7:0]  ctl = {5'b00000, 2'(mode), 1'b0};
        logic [7:0]  rx, v;
        logic [15:0] sig = 16'hFFFF;
        int          errs = 0;
        bit          sticky = 1'b0;
        bit          stopped = 1'b0;

        set_ui(d, ctl);
        @(posedge clk); #1;
        set_ui(d, ctl | 8'h01);
        @(posedge clk); #1;
        for (int j = 0; j < n + l; j++) begin
            if (j == stop_at) begin
                if (stop_rst) rst_n = 1'b0; else ena = 1'b0;
            end
            rx = (j >= l) ? flt(fault_k, pat(d, mode, j - l), m) : 8'hC3;
            set_rx(d, rx);
            cmp_d       = d;
            exp_oe      = ena ? m : 8'h00;
            exp_uo      = {4'b0000, sticky, 3'b001};
            exp_out_vld = (j < n);
            exp_out     = pat(d, mode, j);
            cmp_on      = 1'b1;
            @(posedge clk); #1;
            if (ena && rst_n && j >= l) begin
                if (((rx ^ pat(d, mode, j - l)) & m) != 8'h00) begin
                    errs++;
                    sticky = 1'b1;
                end
                sig = sig_fn(sig, rx & m);
            end
            if (j == stop_at) begin
                stopped = 1'b1;
                break;
            end
        end
        cmp_on = 1'b0;

        if (stopped && stop_rst) begin
            read_uo(d, 2'b00, v); chk("rst_mid_status", {8'h00, v}, 16'h0000);
            chk("rst_mid_oe", {8'h00, get_oe(d)}, 16'h0000);
            chk("rst_mid_out", {8'h00, get_out(d)}, 16'h0000);
            read_uo(d, 2'b01, v); chk("rst_mid_err", {8'h00, v}, 16'h0000);
            read_uo(d, 2'b10, v); chk("rst_mid_sig_lo", {8'h00, v}, 16'h00FF);
            read_uo(d, 2'b11, v); chk("rst_mid_sig_hi", {8'h00, v}, 16'h00FF);
            set_ui(d, 8'h00);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            read_uo(d, 2'b00, v);
            chk("end_status", {8'h00, v},
                {12'h000, sticky, (!stopped && errs == 0), !stopped, 1'b0});
            chk("end_oe", {8'h00, get_oe(d)}, 16'h0000);
            read_uo(d, 2'b01, v);
            chk("end_err", {8'h00, v}, (errs > 255) ? 16'h00FF : 16'(errs));
            read_uo(d, 2'b10, v); chk("end_sig_lo", {8'h00, v}, {8'h00, sig[7:0]});
            read_uo(d, 2'b11, v); chk("end_sig_hi", {8'h00, v}, {8'h00, sig[15:8]});
            read_uo(d, 2'b00, v);
        end
    endtask

    initial begin
        logic [7:0] v;
        rst_n = 1'b0;
        ena   = 1'b1;
        ui0 = 8'h00; ui1 = 8'h00; rx0 = 8'h00; rx1 = 8'h00;

        // Hand-computed values pinning the model.
        chk("model_lfsr1", {8'h00, pat(0, 0, 1)}, 16'h00B8);
        chk("model_lfsr5", {8'h00, pat(0, 0, 5)}, 16'h00B3);
        chk("model_cnt4b", {8'h00, pat(1, 2, 17)}, 16'h0001);
        chk("model_chk1", {8'h00, pat(0, 3, 1)}, 16'h00AA);
        chk("model_sig", sig_fn(16'hFFFF, 8'h01), 16'hEFDE);

        // Reset
        repeat (2) @(posedge clk);
        #1;
        read_uo(0, 2'b00, v); chk("rst_status", {8'h00, v}, 16'h0000);
        chk("rst_oe", {8'h00, oe0}, 16'h0000);
        chk("rst_out", {8'h00, out0}, 16'h0000);
        read_uo(0, 2'b10, v); chk("rst_sig_lo", {8'h00, v}, 16'h00FF);
        read_uo(0, 2'b11, v); chk("rst_sig_hi", {8'h00, v}, 16'h00FF);
        chk("rst_oe_w4", {8'h00, oe1}, 16'h0000);
        chk("rst_out_w4", {8'h00, out1}, 16'h0000);
        set_ui(0, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean LFSR run, then start held high must not retrigger.
        run(0, 0, 0, -1, 1'b0);
        read_uo(0, 2'b00, v); chk("lfsr_status", {8'h00, v}, 16'h0006);
        read_uo(0, 2'b01, v); chk("lfsr_err", {8'h00, v}, 16'h0000);
        read_uo(0, 2'b00, v);
        repeat (4) @(posedge clk);
        #1;
        chk("held_start_status", {8'h00, uo0}, 16'h0006);

        // Stuck-at bit3 with walking one: patterns 3 and 11 fail.
        run(0, 1, 1, -1, 1'b0);
        read_uo(0, 2'b01, v); chk("stuck_err", {8'h00, v}, 16'h0002);
        read_uo(0, 2'b00, v); chk("stuck_status", {8'h00, v}, 16'h000A);

        // Checkerboard restart from DONE clears sticky.
        run(0, 3, 0, -1, 1'b0);
        read_uo(0, 2'b00, v); chk("chk_status", {8'h00, v}, 16'h0006);

        // Abort at cycle 5: four compares made, all failing, results retained.
        run(0, 1, 3, 5, 1'b0);
        read_uo(0, 2'b00, v); chk("abort_status", {8'h00, v}, 16'h0008);
        read_uo(0, 2'b01, v); chk("abort_err", {8'h00, v}, 16'h0004);
        read_uo(0, 2'b00, v);
        ena = 1'b1;

        // Fresh run after abort.
        run(0, 2, 0, -1, 1'b0);
        read_uo(0, 2'b01, v); chk("fresh_err", {8'h00, v}, 16'h0000);
        read_uo(0, 2'b00, v); chk("fresh_status", {8'h00, v}, 16'h0006);

        // Reset at pattern 5.
        run(0, 0, 0, 5, 1'b1);

        // Narrow width: junk on upper uio_in bits is ignored.
        run(1, 2, 4, -1, 1'b0);
        read_uo(1, 2'b00, v); chk("w4_status", {8'h00, v}, 16'h0006);

        // Saturation: 300 mismatches clamp at 255.
        run(1, 0, 2, -1, 1'b0);
        read_uo(1, 2'b01, v); chk("sat_err", {8'h00, v}, 16'h00FF);
        read_uo(1, 2'b00, v); chk("sat_status", {8'h00, v}, 16'h000A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
